// File: rtl/bcm_plane_scheduler_pkg.sv
// Shared types and constants for the BCM bit-plane scheduler.
package bcm_plane_scheduler_pkg;

  // Number of binary-coded-modulation planes (6-bit expanded channels).
  localparam int BCM_PLANES = 6;

  // Bit positions of each colour inside the {r,g,b} column bit.
  localparam int RGB_R_BIT = 2;
  localparam int RGB_G_BIT = 1;
  localparam int RGB_B_BIT = 0;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4,
    ST_HOLD  = 3'd5
  } bcm_state_e;

  // Select one plane bit of a 6-bit channel; out-of-range planes read as 0.
  function automatic logic plane_bit(input logic [5:0] ch, input logic [2:0] p);
    logic b;
    case (p)
      3'd0:    b = ch[0];
      3'd1:    b = ch[1];
      3'd2:    b = ch[2];
      3'd3:    b = ch[3];
      3'd4:    b = ch[4];
      3'd5:    b = ch[5];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bcm_plane_scheduler_rgb565.sv
// RGB565 to 6-bit-per-channel expander; 5-bit channels replicate their LSB.
module bcm_plane_scheduler_rgb565 (
  input  logic [15:0] pix,
  output logic [5:0]  red,
  output logic [5:0]  green,
  output logic [5:0]  blue
);

  assign red   = {pix[15:11], pix[11]};
  assign green = pix[10:5];
  assign blue  = {pix[4:0], pix[0]};

endmodule

// File: rtl/bcm_plane_scheduler.sv
// BCM bit-plane scheduler: walks each row's pixels once per plane, shifts one
// {r,g,b} bit per column over valid/ready, latches the row and holds OE for a
// plane-weighted time. All panel-facing outputs except pix_rgb are registered.
module bcm_plane_scheduler
  import bcm_plane_scheduler_pkg::*;
#(
  parameter int COLS      = 64,
  parameter int ROWS      = 16,
  parameter int BASE_HOLD = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] ram_addr,
  input  logic [15:0]                          ram_data,
  output logic                                 pix_valid,
  input  logic                                 pix_ready,
  output logic [2:0]                           pix_rgb,
  output logic                                 latch,
  output logic                                 oe_n,
  output logic [$clog2(ROWS)-1:0]              row_addr,
  output logic [2:0]                           plane,
  output logic                                 frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = RW + CW;
  localparam int HW = $clog2(BASE_HOLD << 5) + 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [2:0]    PLANE_LAST = 3'(BCM_PLANES - 1);
  localparam logic [HW-1:0] HOLD_BASE  = HW'(BASE_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  bcm_state_e    state_q;
  bcm_state_e    state_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [2:0]    plane_q;
  logic [2:0]    plane_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [HW-1:0] hold_load_s;
  logic [15:0]   pixel_q;
  logic [15:0]   pixel_d;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] ram_addr_d;
  logic [RW-1:0] row_addr_q;
  logic [RW-1:0] row_addr_d;
  logic          pix_valid_q;
  logic          pix_valid_d;
  logic          latch_q;
  logic          latch_d;
  logic          oe_n_q;
  logic          oe_n_d;
  logic          frame_done_q;
  logic          frame_done_d;
  logic [5:0]    red_s;
  logic [5:0]    green_s;
  logic [5:0]    blue_s;
  logic [2:0]    rgb_s;

  // Plane-weighted OE hold length for the current plane.
  assign hold_load_s = HOLD_BASE << plane_q;

  bcm_plane_scheduler_rgb565 u_rgb565 (
    .pix   (pixel_q),
    .red   (red_s),
    .green (green_s),
    .blue  (blue_s)
  );

  // Next-state logic for the FSM and the col/row/plane/hold counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    hold_d  = hold_q;
    pixel_d = pixel_q;
    case (state_q)
      ST_IDLE: begin
        col_d   = '0;
        row_d   = '0;
        plane_d = 3'd0;
        if (enable) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pixel_d = ram_data;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (pix_valid_q && pix_ready) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_LATCH;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        hold_d  = hold_load_s;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hold_d = hold_q - HOLD_ONE;
        if (hold_q <= HOLD_ONE) begin
          hold_d = '0;
          if (plane_q < PLANE_LAST) begin
            plane_d = plane_q + 3'd1;
            state_d = ST_READ;
          end else begin
            plane_d = 3'd0;
            row_d   = row_q + RW'(1);
            if (row_q == ROW_LAST) begin
              // Frame boundary: the only point where a dropped enable takes effect.
              if (enable) begin
                state_d = ST_READ;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_READ;
            end
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    ram_addr_d   = ram_addr_q;
    row_addr_d   = row_addr_q;
    pix_valid_d  = (state_d == ST_SHIFT);
    latch_d      = (state_d == ST_LATCH);
    oe_n_d       = (state_d != ST_HOLD);
    frame_done_d = (state_d == ST_HOLD) && (hold_d == HOLD_ONE) &&
                   (plane_q == PLANE_LAST) && (row_q == ROW_LAST);
    if (state_d == ST_READ) begin
      ram_addr_d = {row_d, col_d};
    end else begin
      ram_addr_d = ram_addr_q;
    end
    if (state_d == ST_LATCH) begin
      row_addr_d = row_d;
    end else begin
      row_addr_d = row_addr_q;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= 3'd0;
      hold_q       <= '0;
      pixel_q      <= 16'h0000;
      ram_addr_q   <= '0;
      row_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      hold_q       <= hold_d;
      pixel_q      <= pixel_d;
      ram_addr_q   <= ram_addr_d;
      row_addr_q   <= row_addr_d;
      pix_valid_q  <= pix_valid_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Column bit for the current plane; forced to 0 whenever no bit is offered.
  always_comb begin
    rgb_s = 3'b000;
    if (pix_valid_q) begin
      rgb_s[RGB_R_BIT] = plane_bit(red_s, plane_q);
      rgb_s[RGB_G_BIT] = plane_bit(green_s, plane_q);
      rgb_s[RGB_B_BIT] = plane_bit(blue_s, plane_q);
    end else begin
      rgb_s = 3'b000;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign row_addr   = row_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_rgb    = rgb_s;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign plane      = plane_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcm_plane_scheduler.sv
// Self-checking bench for bcm_plane_scheduler (COLS=4, ROWS=2, BASE_HOLD=2).
// The expected cycle-by-cycle trace is unrolled from frame/row/plane/column
// loops and replayed against the DUT, together with literal spot checks.
module tb_bcm_plane_scheduler;

  localparam int COLS      = 4;
  localparam int ROWS      = 2;
  localparam int BASE_HOLD = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  ram_addr;
  logic [15:0] ram_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  pix_rgb;
  logic        latch;
  logic        oe_n;
  logic [0:0]  row_addr;
  logic [2:0]  plane;
  logic        frame_done;

  logic [15:0] mem [8];

  typedef struct {
    bit         rst;
    bit         en;
    bit         rdy;
    bit         is_read;
    bit         post;
    int         ftag;
    logic [3:0] addr;
    logic       valid;
    logic [2:0] rgb;
    logic       latch;
    logic       oe_n;
    logic [0:0] row;
    logic [2:0] plane;
    logic       fd;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_addr;
  logic [0:0] m_disp;
  int         abort_idx;
  int         n_checks;
  int         n_pass;
  int         bad_f800;
  int         fd_cnt;
  int         oe_run;
  int         max_run;
  logic [3:0] addr_log[$];
  logic [2:0] cap[6];

  bcm_plane_scheduler #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BASE_HOLD (BASE_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_rgb    (pix_rgb),
    .latch      (latch),
    .oe_n       (oe_n),
    .row_addr   (row_addr),
    .plane      (plane),
    .frame_done (frame_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer read port: data is valid one cycle after the address.
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected {r,g,b} bit of plane p for RGB565 pixel d, by plain arithmetic.
  function automatic logic [2:0] exp_bits(input logic [15:0] d, input int p);
    int v;
    int r6;
    int g6;
    int b6;
    v  = int'(d);
    r6 = ((v >> 11) % 32) * 2 + ((v >> 11) % 2);
    g6 = (v >> 5) % 64;
    b6 = (v % 32) * 2 + (v % 2);
    return {1'((r6 >> p) % 2), 1'((g6 >> p) % 2), 1'((b6 >> p) % 2)};
  endfunction

  // Default trace entry: dark, idle-looking outputs at the current model address/row.
  function automatic ent_t mk(input bit en, input logic [2:0] pl, input int ftag);
    ent_t e;
    e.rst = 1'b0; e.en = en; e.rdy = 1'b1; e.is_read = 1'b0; e.post = 1'b0;
    e.ftag = ftag; e.addr = m_addr; e.valid = 1'b0; e.rgb = 3'b000;
    e.latch = 1'b0; e.oe_n = 1'b1; e.row = m_disp; e.plane = pl; e.fd = 1'b0;
    return e;
  endfunction

  // Unroll one frame into the trace: per pixel READ, WAIT, SHIFT(+stall), then LATCH and HOLD.
  task automatic build_frame(input bit from_idle, input bit en_row1, input bit en_end,
                             input int stall_addr, input int ftag, input bit abort);
    ent_t e;
    int   n;
    int   a;
    bit   en;
    if (from_idle) begin
      e = mk(1'b1, 3'd0, ftag);
      q.push_back(e);
    end
    for (int r = 0; r < ROWS; r++) begin
      en = (r == 0) ? 1'b1 : en_row1;
      for (int p = 0; p < 6; p++) begin
        for (int c = 0; c < COLS; c++) begin
          a = r * COLS + c;
          m_addr = 4'(a);
          e = mk(en, 3'(p), ftag); e.is_read = 1'b1; q.push_back(e);
          e = mk(en, 3'(p), ftag); q.push_back(e);
          n = (a == stall_addr && p == 0) ? 5 : 0;
          for (int s = 0; s <= n; s++) begin
            e = mk(en, 3'(p), ftag);
            e.valid = 1'b1;
            e.rgb   = exp_bits(mem[a], p);
            e.rdy   = (s == n) ? 1'b1 : 1'b0;
            q.push_back(e);
          end
        end
        m_disp = 1'(r);
        e = mk(en, 3'(p), ftag); e.latch = 1'b1; q.push_back(e);
        n = BASE_HOLD << p;
        for (int h = 0; h < n; h++) begin
          e = mk(en, 3'(p), ftag);
          e.oe_n = 1'b0;
          if (r == ROWS - 1 && p == 5 && h == n - 1) begin
            e.fd = 1'b1;
            e.en = en_end;
          end
          q.push_back(e);
          if (abort && r == 1 && p == 3 && h == 2) abort_idx = q.size() - 1;
        end
      end
    end
  endtask

  // Replay the trace: compare this cycle's outputs, then drive this cycle's inputs.
  task automatic run_trace();
    ent_t        e;
    logic [14:0] act_v;
    logic [14:0] exp_v;
    for (int k = 0; k < q.size(); k++) begin
      e = q[k];
      @(negedge clk);
      act_v = {ram_addr, pix_valid, pix_rgb, latch, oe_n, row_addr, plane, frame_done};
      exp_v = {e.addr, e.valid, e.rgb, e.latch, e.oe_n, e.row, e.plane, e.fd};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL cycle%0d {addr,valid,rgb,latch,oe_n,row,plane,fd}: got %b expected %b",
                    k, act_v, exp_v);
      if (oe_n === 1'b0) oe_run++;
      else oe_run = 0;
      if (oe_run > max_run) max_run = oe_run;
      if (frame_done === 1'b1) fd_cnt++;
      if (e.ftag == 1 && e.is_read) addr_log.push_back(ram_addr);
      if (e.ftag == 1 && e.valid && pix_rgb !== 3'b100) bad_f800++;
      if (e.ftag == 2 && e.valid && e.addr == 4'd0) cap[e.plane] = pix_rgb;
      if (e.post) begin
        chk("post_rst_oe_n", 32'(oe_n), 32'd1);
        chk("post_rst_plane", 32'(plane), 32'd0);
        chk("post_rst_row_addr", 32'(row_addr), 32'd0);
        chk("post_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("post_rst_ram_addr", 32'(ram_addr), 32'd0);
      end
      reset     = e.rst;
      enable    = e.en;
      pix_ready = e.rdy;
    end
  endtask

  // Directed sequence: reset, red frame with enable dropped, mixed frame with stall, aborted frame.
  initial begin
    ent_t       e;
    int         mism;
    int         expa;
    logic [2:0] exp0821 [6];
    exp0821 = '{3'b111, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
    n_checks = 0; n_pass = 0; bad_f800 = 0; fd_cnt = 0; oe_run = 0; max_run = 0;
    abort_idx = 0;
    reset = 1'b1; enable = 1'b0; pix_ready = 1'b0; ram_data = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = 16'hF800;
    m_addr = 4'd0; m_disp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_row_addr", 32'(row_addr), 32'd0);
    chk("rst_plane", 32'(plane), 32'd0);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    reset = 1'b0;

    // Frame A: all red, enable low from row 1 on, frame ends in IDLE.
    build_frame(1'b1, 1'b0, 1'b0, -1, 1, 1'b0);
    repeat (4) q.push_back(mk(1'b0, 3'd0, 0));
    run_trace();
    q.delete();
    chk("f800_rgb_bad_count", 32'(bad_f800), 32'd0);
    chk("frame_a_done_pulses", 32'(fd_cnt), 32'd1);
    chk("addr_seq_len", 32'(addr_log.size()), 32'd48);
    mism = 0;
    for (int k = 0; k < 48 && k < addr_log.size(); k++) begin
      expa = (k < 24) ? (k % 4) : (4 + k % 4);
      if (addr_log[k] !== 4'(expa)) mism++;
    end
    chk("addr_seq_mismatches", 32'(mism), 32'd0);

    // Frame B: mixed pixels with a 5-cycle stall, enable kept high; frame C aborted by reset.
    mem[0] = 16'h0821; mem[1] = 16'hF800; mem[2] = 16'h07E0; mem[3] = 16'h001F;
    mem[4] = 16'hA5A5; mem[5] = 16'h5A5A; mem[6] = 16'hFFFF; mem[7] = 16'h1234;
    build_frame(1'b1, 1'b1, 1'b1, 1, 2, 1'b0);
    build_frame(1'b0, 1'b1, 1'b1, -1, 0, 1'b1);
    q = q[0:abort_idx];
    q[abort_idx].rst = 1'b1;
    m_addr = 4'd0; m_disp = 1'b0;
    e = mk(1'b0, 3'd0, 0); e.post = 1'b1; q.push_back(e);
    repeat (3) q.push_back(mk(1'b0, 3'd0, 0));
    run_trace();
    for (int p = 0; p < 6; p++) chk($sformatf("px0821_plane%0d", p), 32'(cap[p]), 32'(exp0821[p]));
    chk("total_done_pulses", 32'(fd_cnt), 32'd2);
    chk("plane5_oe_low_cycles", 32'(max_run), 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
